// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write path.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EN_HI,
      HOLD,
      WAIT_EXEC
   } lcd_state_e;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   // Clear display and return home both take the long execution time;
   // any non-zero command using only bits [1:0] belongs to that group.
   function automatic logic is_clear_home(input logic rs, input logic [7:0] d);
      return !rs && ((d | CMD_CLEAR | CMD_HOME) == (CMD_CLEAR | CMD_HOME)) && (d != 8'h00);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Shared phase timer: loads on state entry, counts down, flags zero.
module lcd_delay_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// Write-only LCD bus sequencer: setup / enable / hold strobing per byte or
// nibble, followed by the controller's execution wait.
module lcd_write_engine
   import lcd_pkg::*;
#(
   parameter int BUS4    = 0,
   parameter int T_SETUP = 4,
   parameter int T_EN    = 12,
   parameter int T_HOLD  = 4,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 80000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid,
   input  logic       rs_in,
   input  logic [7:0] data_in,
   output logic       ready,
   output logic       done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_d
);

   localparam int T_MAX = max2(max2(max2(T_SETUP, T_EN), max2(T_HOLD, T_CMD)), T_CLR);
   localparam int CW    = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD - 1);
   localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR - 1);

   if (T_SETUP < 1 || T_EN < 1 || T_HOLD < 1 || T_CMD < 1 || T_CLR < 1 ||
       (BUS4 != 0 && BUS4 != 1)) begin : g_param_check
      $error("lcd_write_engine: T_* parameters must be >= 1 and BUS4 must be 0 or 1");
   end

   lcd_state_e      state_q, state_d;
   logic            rs_q, rs_d;
   logic [7:0]      data_q, data_d;
   logic            phase_q, phase_d;
   logic            done_q, done_d;
   logic            e_q, e_d;
   logic [7:0]      bus_q, bus_d;
   logic            cnt_load;
   logic [CW-1:0]   cnt_val;
   logic            cnt_zero;

   lcd_delay_counter #(.W(CW)) u_delay (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      rs_d     = rs_q;
      data_d   = data_q;
      phase_d  = phase_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state_q)
         IDLE: begin
            if (valid) begin
               rs_d     = rs_in;
               data_d   = data_in;
               phase_d  = 1'b0;
               state_d  = SETUP;
               cnt_load = 1'b1;
               cnt_val  = LD_SETUP;
            end
         end
         SETUP: begin
            if (cnt_zero) begin
               state_d  = EN_HI;
               cnt_load = 1'b1;
               cnt_val  = LD_EN;
            end
         end
         EN_HI: begin
            if (cnt_zero) begin
               state_d  = HOLD;
               cnt_load = 1'b1;
               cnt_val  = LD_HOLD;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               cnt_load = 1'b1;
               if (BUS4 != 0 && !phase_q) begin
                  phase_d = 1'b1;
                  state_d = SETUP;
                  cnt_val = LD_SETUP;
               end else begin
                  state_d = WAIT_EXEC;
                  cnt_val = is_clear_home(rs_q, data_q) ? LD_CLR : LD_CMD;
               end
            end
         end
         WAIT_EXEC: begin
            if (cnt_zero) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from next-state values so they line up with state_q.
      e_d = (state_d == EN_HI);
      if (BUS4 != 0) begin
         bus_d = {(phase_d ? data_d[3:0] : data_d[7:4]), 4'h0};
      end else begin
         bus_d = data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rs_q    <= 1'b0;
         data_q  <= '0;
         phase_q <= 1'b0;
         done_q  <= 1'b0;
         e_q     <= 1'b0;
         bus_q   <= '0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         phase_q <= phase_d;
         done_q  <= done_d;
         e_q     <= e_d;
         bus_q   <= bus_d;
      end
   end

   assign ready  = (state_q == IDLE);
   assign done   = done_q;
   assign lcd_rs = rs_q;
   assign lcd_rw = 1'b0;
   assign lcd_e  = e_q;
   assign lcd_d  = bus_q;

endmodule
